// File: rtl/fast_square_sweep_ctrl_pkg.sv
// Shared types, widths and default settings-bus addresses for the square-sweep controller.
package fast_square_sweep_ctrl_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned STEP_W = 12;

    localparam int unsigned DEF_RECLENADDR   = 3;
    localparam int unsigned DEF_GAPLENADDR   = 4;
    localparam int unsigned DEF_NUMSTEPSADDR = 5;
    localparam int unsigned DEF_CTRLADDR     = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_RECORD,
        ST_STEP
    } state_t;

    // Sweep settings captured at sweep start so bus writes cannot disturb a running sweep.
    typedef struct packed {
        logic [LEN_W-1:0]  rec_len;
        logic [LEN_W-1:0]  gap_len;
        logic [STEP_W-1:0] num_steps;
    } sweep_cfg_t;

    function automatic logic [LEN_W-1:0] at_least_one(input logic [LEN_W-1:0] v);
        return (v == '0) ? LEN_W'(1) : v;
    endfunction

endpackage

// File: rtl/setting_reg.sv
// Settings-bus register: captures the low WIDTH data bits on a write to MY_ADDR; not reset.
module setting_reg
    import fast_square_sweep_ctrl_pkg::*;
#(
    parameter int unsigned MY_ADDR = 0,
    parameter int unsigned WIDTH   = 16
) (
    input  logic              clock,
    input  logic              strobe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  data,
    output logic [WIDTH-1:0]  out
);

    always_ff @(posedge clock) begin
        if (strobe && (addr == ADDR_W'(MY_ADDR))) begin
            out <= data;
        end
    end

endmodule

// File: rtl/fast_square_sweep_ctrl.sv
// Square-wave frequency sweep sequencer: LOAD, then per step GAP -> RECORD -> STEP.
// Define SWEEP_LOOP_EN to restart the sweep continuously until abort or reset.
module fast_square_sweep_ctrl
    import fast_square_sweep_ctrl_pkg::*;
#(
    parameter int unsigned RECLENADDR   = DEF_RECLENADDR,
    parameter int unsigned GAPLENADDR   = DEF_GAPLENADDR,
    parameter int unsigned NUMSTEPSADDR = DEF_NUMSTEPSADDR,
    parameter int unsigned CTRLADDR     = DEF_CTRLADDR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] serial_addr,
    input  logic [DATA_W-1:0] serial_data,
    input  logic              serial_strobe,
    output logic              record,
    output logic              freq_step,
    output logic              sweep_restart,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step_index
);

    logic [LEN_W-1:0]  rec_len_reg;
    logic [LEN_W-1:0]  gap_len_reg;
    logic [STEP_W-1:0] num_steps_reg;

    setting_reg #(.MY_ADDR(RECLENADDR), .WIDTH(LEN_W)) u_rec_len (
        .clock  (clock),
        .strobe (serial_strobe),
        .addr   (serial_addr),
        .data   (serial_data[LEN_W-1:0]),
        .out    (rec_len_reg)
    );

    setting_reg #(.MY_ADDR(GAPLENADDR), .WIDTH(LEN_W)) u_gap_len (
        .clock  (clock),
        .strobe (serial_strobe),
        .addr   (serial_addr),
        .data   (serial_data[LEN_W-1:0]),
        .out    (gap_len_reg)
    );

    setting_reg #(.MY_ADDR(NUMSTEPSADDR), .WIDTH(STEP_W)) u_num_steps (
        .clock  (clock),
        .strobe (serial_strobe),
        .addr   (serial_addr),
        .data   (serial_data[STEP_W-1:0]),
        .out    (num_steps_reg)
    );

    wire unused_serial_hi = &{1'b0, serial_data[DATA_W-1:LEN_W]};

    state_t            state_q, state_d;
    sweep_cfg_t        cfg_q;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              latch_c;
    logic              ctrl_wr_c, start_req_c, abort_c;
    logic [STEP_W-1:0] last_idx_c;
    logic [LEN_W-1:0]  rec_load_c, gap_load_c;
    logic              record_d, freq_step_d, sweep_restart_d, busy_d, done_d;

    assign ctrl_wr_c   = serial_strobe && (serial_addr == ADDR_W'(CTRLADDR));
    assign start_req_c = start || (ctrl_wr_c && serial_data[0]);
    assign abort_c     = ctrl_wr_c && serial_data[1];
    assign last_idx_c  = (cfg_q.num_steps == '0) ? '0 : cfg_q.num_steps - STEP_W'(1);
    assign rec_load_c  = at_least_one(cfg_q.rec_len) - LEN_W'(1);
    assign gap_load_c  = cfg_q.gap_len - LEN_W'(1);
    assign step_index  = step_q;

    // Next state; every registered output is decoded from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        latch_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_req_c) begin
                    state_d = ST_LOAD;
                    latch_c = 1'b1;
                    step_d  = '0;
                end
            end
            ST_LOAD: begin
                if (cfg_q.gap_len != '0) begin
                    state_d = ST_GAP;
                    cnt_d   = gap_load_c;
                end else begin
                    state_d = ST_RECORD;
                    cnt_d   = rec_load_c;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_RECORD;
                    cnt_d   = rec_load_c;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            ST_RECORD: begin
                if (cnt_q == '0) begin
                    state_d = ST_STEP;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            ST_STEP: begin
                if (step_q == last_idx_c) begin
`ifdef SWEEP_LOOP_EN
                    state_d = ST_LOAD;
                    latch_c = 1'b1;
                    step_d  = '0;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    step_d = step_q + STEP_W'(1);
                    if (cfg_q.gap_len != '0) begin
                        state_d = ST_GAP;
                        cnt_d   = gap_load_c;
                    end else begin
                        state_d = ST_RECORD;
                        cnt_d   = rec_load_c;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a start in the same cycle.
        if (abort_c) begin
            state_d = ST_IDLE;
            latch_c = 1'b0;
            step_d  = step_q;
            cnt_d   = cnt_q;
        end

        record_d        = (state_d == ST_RECORD);
        freq_step_d     = (state_d == ST_STEP);
        sweep_restart_d = (state_d == ST_LOAD);
        busy_d          = (state_d != ST_IDLE);
        done_d          = (state_d == ST_STEP) && (step_d == last_idx_c);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cfg_q         <= '0;
            cnt_q         <= '0;
            step_q        <= '0;
            record        <= 1'b0;
            freq_step     <= 1'b0;
            sweep_restart <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            step_q        <= step_d;
            record        <= record_d;
            freq_step     <= freq_step_d;
            sweep_restart <= sweep_restart_d;
            busy          <= busy_d;
            done          <= done_d;
            if (latch_c) begin
                cfg_q <= '{rec_len: rec_len_reg, gap_len: gap_len_reg, num_steps: num_steps_reg};
            end
        end
    end

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Directed bench for fast_square_sweep_ctrl; per-cycle expected outputs are queued and checked on negedge.
module tb_fast_square_sweep_ctrl;

    localparam int A_REC  = 3;
    localparam int A_GAP  = 4;
    localparam int A_NUM  = 5;
    localparam int A_CTRL = 6;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;
    logic        record, freq_step, sweep_restart, busy, done;
    logic [11:0] step_index;

    typedef struct packed {
        logic        record;
        logic        freq_step;
        logic        sweep_restart;
        logic        busy;
        logic        done;
        logic [11:0] step_index;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cur_idx = 0;

    fast_square_sweep_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .record        (record),
        .freq_step     (freq_step),
        .sweep_restart (sweep_restart),
        .busy          (busy),
        .done          (done),
        .step_index    (step_index)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        obs_t o;
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = {record, freq_step, sweep_restart, busy, done, step_index};
            total++;
            assert (o === e.v) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h (rec,fs,sr,busy,done,idx)", e.tag, o, e.v);
            end
        end
    end

    function automatic void push(string tag, bit rec, bit fs, bit sr, bit bz, bit dn, int idx);
        exp_t e;
        e.tag = tag;
        e.v   = '{record: rec, freq_step: fs, sweep_restart: sr, busy: bz, done: dn,
                  step_index: 12'(idx)};
        exp_q.push_back(e);
    endfunction

    // One pass as the sweep is described: LOAD, then per step gap, record, step.
    function automatic void push_pass(string tag, int g, int r, int n);
        int ne = (n == 0) ? 1 : n;
        int re = (r == 0) ? 1 : r;
        push(tag, 0, 0, 1, 1, 0, 0);
        for (int s = 0; s < ne; s++) begin
            for (int k = 0; k < g; k++) push(tag, 0, 0, 0, 1, 0, s);
            for (int k = 0; k < re; k++) push(tag, 1, 0, 0, 1, 0, s);
            push(tag, 0, 1, 0, 1, (s == ne - 1), s);
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(int a, int d);
        serial_addr   = 7'(a);
        serial_data   = 32'(d);
        serial_strobe = 1'b1;
        tick();
        serial_strobe = 1'b0;
    endtask

    task automatic drain(string tag);
        int budget = exp_q.size() + 8;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL %s_drain observed_left=%0d expected_left=0", tag, exp_q.size());
        end
    endtask

    task automatic keep_first(int n);
        while (exp_q.size() > n) void'(exp_q.pop_back());
    endtask

    task automatic run_sweep(string tag, int g, int r, int n);
        int ne = (n == 0) ? 1 : n;
        push(tag, 0, 0, 0, 0, 0, cur_idx);
        push_pass(tag, g, r, n);
        push(tag, 0, 0, 0, 0, 0, ne - 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(tag);
        cur_idx = ne - 1;
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        serial_addr   = '0;
        serial_data   = '0;
        serial_strobe = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        push("reset", 0, 0, 0, 0, 0, 0);
        push("reset", 0, 0, 0, 0, 0, 0);
        drain("reset");

`ifdef SWEEP_LOOP_EN
        wr(A_GAP, 0); wr(A_REC, 1); wr(A_NUM, 2);
        push("loop", 0, 0, 0, 0, 0, cur_idx);
        push_pass("loop", 0, 1, 2);
        push_pass("loop", 0, 1, 2);
        push("loop_abort", 0, 0, 0, 0, 0, 1);
        push("loop_abort", 0, 0, 0, 0, 0, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        wr(A_CTRL, 2);
        drain("loop");
`else
        wr(A_GAP, 2); wr(A_REC, 4); wr(A_NUM, 3);
        run_sweep("basic", 2, 4, 3);

        wr(A_GAP, 0); wr(A_REC, 0); wr(A_NUM, 0);
        run_sweep("zero_cfg", 0, 0, 0);

        // Abort while recording: t0 idle, LOAD, 1 gap, record, record <- abort written here.
        wr(A_GAP, 1); wr(A_REC, 3); wr(A_NUM, 2);
        push("abort", 0, 0, 0, 0, 0, cur_idx);
        push_pass("abort", 1, 3, 2);
        keep_first(5);
        push("abort", 0, 0, 0, 0, 0, 0);
        push("abort", 0, 0, 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        wr(A_CTRL, 2);
        drain("abort");
        cur_idx = 0;

        repeat (3) push("abort_vs_start", 0, 0, 0, 0, 0, 0);
        start = 1'b1;
        wr(A_CTRL, 3);
        start = 1'b0;
        drain("abort_vs_start");

        run_sweep("after_abort", 1, 3, 2);

        // Restart request and record-length write mid-sweep leave this sweep untouched.
        wr(A_REC, 2);
        push("midsweep", 0, 0, 0, 0, 0, cur_idx);
        push_pass("midsweep", 1, 2, 2);
        push("midsweep", 0, 0, 0, 0, 0, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        wr(A_REC, 5);
        start = 1'b0;
        drain("midsweep");
        cur_idx = 1;
        run_sweep("new_len", 1, 5, 2);

        // Reset in the gap of step 1 (cycle t8), outputs cleared from t9.
        wr(A_GAP, 3); wr(A_REC, 1); wr(A_NUM, 3);
        push("reset_mid", 0, 0, 0, 0, 0, cur_idx);
        push_pass("reset_mid", 3, 1, 3);
        keep_first(9);
        push("reset_mid", 0, 0, 0, 0, 0, 0);
        push("reset_mid", 0, 0, 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drain("reset_mid");
        cur_idx = 0;
        run_sweep("post_reset", 3, 1, 3);

        wr(A_GAP, 300); wr(A_REC, 258); wr(A_NUM, 1);
        run_sweep("long_len", 300, 258, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fast_square_sweep_ctrl.md
FAST_SQUARE_SWEEP_CTRL -- requirements
Module: fast_square_sweep_ctrl

Interface
REQ-001 Parameter RECLENADDR, default 3: serial address of record-length register (bits 15:0, cycles).
REQ-002 Parameter GAPLENADDR, default 4: serial address of gap-length register (bits 15:0, cycles).
REQ-003 Parameter NUMSTEPSADDR, default 5: serial address of step-count register (bits 11:0).
REQ-004 Parameter CTRLADDR, default 6: serial address of control register (bit0 start, bit1 abort; write-strobe pulses).
REQ-005 clock  input  1  system clock; the only clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  hardware sweep start pulse.
REQ-008 serial_addr  input  7  settings bus address.
REQ-009 serial_data  input  32  settings bus data.
REQ-010 serial_strobe  input  1  settings bus write strobe.
REQ-011 record  output  1  record gate to the downstream receiver.
REQ-012 freq_step  output  1  one-cycle frequency-step/latch pulse to the downstream receiver.
REQ-013 sweep_restart  output  1  one-cycle pulse that resets and reloads the downstream receiver.
REQ-014 busy  output  1  high while a sweep is in progress.
REQ-015 done  output  1  one-cycle pulse when the final step completes.
REQ-016 step_index  output  12  index of the current step, 0-based.

Function
REQ-017 States SHALL be IDLE, LOAD, GAP, RECORD, STEP; all outputs registered.
REQ-018 IDLE: start=1, or a CTRLADDR write with bit0=1, SHALL latch record length, gap length and step count, and enter LOAD.
REQ-019 LOAD SHALL last one cycle with sweep_restart=1, step_index=0, busy=1.
REQ-020 GAP SHALL last gap_len cycles with record=0; gap_len=0 skips GAP (LOAD/STEP go straight to RECORD).
REQ-021 RECORD SHALL last max(record_len,1) cycles with record=1 throughout.
REQ-022 STEP SHALL last one cycle with freq_step=1 and record=0; record and freq_step are never both high.
REQ-023 On leaving STEP with step_index < max(num_steps,1)-1: increment step_index, go to GAP.
REQ-024 Otherwise: assert done in the STEP cycle, go to IDLE; busy low the next cycle; step_index holds its last value.
REQ-025 Start requests while busy=1 SHALL be ignored; settings writes while busy SHALL NOT affect the running sweep.
REQ-026 A CTRLADDR write with bit1=1 SHALL force IDLE next cycle, with record, freq_step, busy low and no done pulse; abort wins over a simultaneous start.
REQ-027 Length counters SHALL be 16-bit down-counters; no wrap: 0xFFFF yields exactly 65535 cycles.

Reset
REQ-028 Reset SHALL force IDLE; record, freq_step, sweep_restart, busy, done=0; step_index=0; latched lengths=0.
REQ-029 Reset mid-sweep SHALL drop record and busy in the cycle after reset is sampled, with no freq_step or done emitted.
REQ-030 Settings registers SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro SWEEP_LOOP_EN. Defined: after the final STEP, go to LOAD instead of IDLE; re-latch settings; pulse sweep_restart; step_index=0; pulse done each pass; busy stays high until abort or reset. Undefined: single sweep per REQ-024.

Structure
REQ-032 Shared package SHALL hold the state encoding and default register addresses.
REQ-033 The settings registers SHALL be instances of the existing setting_reg sub-module; no other sub-modules.

Verification
REQ-034 gap=2, rec=4, steps=3, start at t0 -> sweep_restart t1; record t4-7, t11-14, t18-21; freq_step t8, t15, t22; done t22; busy low t23.
REQ-035 gap=0, rec=0, steps=0 -> LOAD, 1 record cycle, 1 freq_step cycle, done, IDLE; 3 busy cycles total.
REQ-036 Abort write during a RECORD cycle -> record and busy low the next cycle; no freq_step or done; a new start is accepted.
REQ-037 Second start and a RECLENADDR write mid-sweep -> no effect on timing; the new length takes effect on the next sweep only.
REQ-038 Reset asserted in GAP of step 1 -> all outputs 0 the next cycle; step_index=0.
REQ-039 SWEEP_LOOP_EN, steps=2 -> sweep_restart pulses before each pass, done per pass, busy continuous until abort.
